// File: rtl/decred_spi_pkg.sv
// Shared constants for the Wishbone-to-SPI host bridge that drives the decred_top miner.
package decred_spi_pkg;

  // Register offsets, decoded from adr[3:2]
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegData   = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;

  // CTRL bit positions (div occupies the low DIV_W bits)
  localparam int unsigned CtrlCsnBit    = 8;
  localparam int unsigned CtrlExtRstBit = 9;
  localparam int unsigned CtrlIrqEnBit  = 10;

  // STATUS bit positions
  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatOvrBit  = 1;
  localparam int unsigned StatIrqBit  = 2;
  localparam int unsigned StatDoneBit = 3;

  localparam int unsigned XferBits  = 8;
  localparam int unsigned HalfCount = 2 * XferBits;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } eng_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shifter: half-period divider, sclk/mosi generation and MSB-first rx capture.
module spi_shift_engine
  import decred_spi_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic [DIV_W-1:0] div,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_byte
);

  eng_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [3:0]       half_q;
  logic             sclk_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic [7:0]       rx_byte_q;
  logic             expire;
  logic             last_half;

  assign expire    = (state_q == StShift) && (cnt_q == '0);
  assign last_half = expire && (half_q == 4'(HalfCount - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_half) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
    done = last_half;
    sclk = sclk_q;
    mosi = busy & tx_q[7];
  end

  // The counter reloads from the live div, so a new divider lands at the next half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      half_q    <= '0;
      sclk_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_byte_q <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        cnt_q  <= div;
        half_q <= '0;
        sclk_q <= 1'b0;
        tx_q   <= tx_byte;
        rx_q   <= '0;
      end
    end else if (expire) begin
      cnt_q  <= div;
      half_q <= half_q + 4'd1;
      sclk_q <= ~sclk_q;
      // End of a high phase: sample miso, then either shift mosi or finish the byte.
      if (sclk_q) begin
        rx_q <= {rx_q[6:0], miso};
        if (last_half) begin
          rx_byte_q <= {rx_q[6:0], miso};
        end else begin
          tx_q <= {tx_q[6:0], 1'b0};
        end
      end
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign rx_byte = rx_byte_q;

endmodule

// File: rtl/wb_spi_host_bridge.sv
// Wishbone slave giving the management SoC register-driven SPI host access to decred_top.
module wb_spi_host_bridge
  import decred_spi_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        spi_csn_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        ext_reset_n_o,
  input  logic        irq_i,
  output logic        irq_o
);

  logic             ack_q;
  logic [DIV_W-1:0] div_q;
  logic             csn_q;
  logic             ext_rst_n_q;
  logic             irq_en_q;
  logic             ovr_q;
  logic             done_q;
  logic             miso_s1, miso_sync;
  logic             irq_s1, irq_sync;

  logic             req;
  logic             wr;
  logic [1:0]       reg_sel;
  logic             ctrl_wr;
  logic             data_wr;
  logic             stat_wr;
  logic             start;
  logic             ovr_set;
  logic             busy;
  logic             done_pulse;
  logic [7:0]       rx_byte;
  logic [31:0]      rdata;
  logic             unused_inputs;

  assign reg_sel = wbs_adr_i[3:2];
  assign req     = wbs_stb_i & wbs_cyc_i;
  // Writes commit on the ack cycle, while the master still holds the request.
  assign wr      = ack_q & req & wbs_we_i;
  assign ctrl_wr = wr && (reg_sel == RegCtrl);
  assign data_wr = wr && (reg_sel == RegData) && wbs_sel_i[0];
  assign stat_wr = wr && (reg_sel == RegStatus) && wbs_sel_i[0];
  assign start   = data_wr & ~busy;
  assign ovr_set = data_wr & busy;

  assign unused_inputs = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:11], wbs_sel_i[3:2]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      div_q       <= '0;
      csn_q       <= 1'b1;
      ext_rst_n_q <= 1'b0;
      irq_en_q    <= 1'b0;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      miso_s1     <= 1'b0;
      miso_sync   <= 1'b0;
      irq_s1      <= 1'b0;
      irq_sync    <= 1'b0;
    end else begin
      ack_q     <= req & ~ack_q;
      miso_s1   <= spi_miso_i;
      miso_sync <= miso_s1;
      irq_s1    <= irq_i;
      irq_sync  <= irq_s1;
      if (ctrl_wr && wbs_sel_i[0]) begin
        div_q <= wbs_dat_i[DIV_W-1:0];
      end
      if (ctrl_wr && wbs_sel_i[1]) begin
        csn_q       <= wbs_dat_i[CtrlCsnBit];
        ext_rst_n_q <= wbs_dat_i[CtrlExtRstBit];
        irq_en_q    <= wbs_dat_i[CtrlIrqEnBit];
      end
      // A set event in the same cycle as a W1C wins.
      ovr_q  <= ovr_set | (ovr_q & ~(stat_wr & wbs_dat_i[StatOvrBit]));
      done_q <= done_pulse | (done_q & ~(stat_wr & wbs_dat_i[StatDoneBit]));
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegCtrl: begin
        rdata[DIV_W-1:0]     = div_q;
        rdata[CtrlCsnBit]    = csn_q;
        rdata[CtrlExtRstBit] = ext_rst_n_q;
        rdata[CtrlIrqEnBit]  = irq_en_q;
      end
      RegData: rdata[7:0] = rx_byte;
      RegStatus: begin
        rdata[StatBusyBit] = busy;
        rdata[StatOvrBit]  = ovr_q;
        rdata[StatIrqBit]  = irq_sync;
        rdata[StatDoneBit] = done_q;
      end
      default: rdata = '0;
    endcase
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = ack_q ? rdata : '0;
  assign spi_csn_o     = csn_q;
  assign ext_reset_n_o = ext_rst_n_q;
  assign irq_o         = irq_sync & irq_en_q;

  spi_shift_engine #(
    .DIV_W(DIV_W)
  ) u_engine (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .start   (start),
    .tx_byte (wbs_dat_i[7:0]),
    .div     (div_q),
    .miso    (miso_sync),
    .sclk    (spi_sclk_o),
    .mosi    (spi_mosi_o),
    .busy    (busy),
    .done    (done_pulse),
    .rx_byte (rx_byte)
  );

endmodule

// File: tb/tb_wb_spi_host_bridge.sv
// Self-checking bench for wb_spi_host_bridge: register table, SPI waveform model and corner cases.
module tb_wb_spi_host_bridge;

  localparam logic [31:0] AdrCtrl   = 32'h0;
  localparam logic [31:0] AdrData   = 32'h4;
  localparam logic [31:0] AdrStatus = 32'h8;
  localparam logic [31:0] AdrRsvd   = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        csn, sclk, mosi, miso, ext_n, irq_in = 1'b0, irq_out;

  always #5 clk = ~clk;

  wb_spi_host_bridge #(
    .DIV_W(8)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .spi_csn_o     (csn),
    .spi_sclk_o    (sclk),
    .spi_mosi_o    (mosi),
    .spi_miso_i    (miso),
    .ext_reset_n_o (ext_n),
    .irq_i         (irq_in),
    .irq_o         (irq_out)
  );

  // Behavioural SPI slave: presents its byte MSB first, shifts on sclk fall, captures on rise.
  logic       slave_load = 1'b0;
  logic [7:0] slave_preset = 8'h00;
  logic [7:0] slave_tx = 8'h00, slave_rx = 8'h00;
  logic       sclk_prev = 1'b0;
  bit         loopback = 1'b0;

  always @(posedge clk) begin
    sclk_prev <= sclk;
    if (slave_load) begin
      slave_tx <= slave_preset;
      slave_rx <= 8'h00;
    end else begin
      if (sclk_prev && !sclk) slave_tx <= {slave_tx[6:0], 1'b0};
      if (!sclk_prev && sclk) slave_rx <= {slave_rx[6:0], mosi};
    end
  end

  assign miso = loopback ? mosi : slave_tx[7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that follows the ack cycle.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    int waited = 0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!ack && waited < 8);
    check("ack_latency", 32'(waited), 32'd1);
    r = rdat;
    @(posedge clk); #1;
    check("ack_single", 32'(ack), 32'd0);
    check("dat_idle_zero", rdat, 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, s, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic load_slave(input logic [7:0] b, input bit loop);
    loopback = loop;
    slave_preset = b;
    slave_load = 1'b1;
    @(posedge clk); #1;
    slave_load = 1'b0;
  endtask

  // One full transfer at divider d, checked cycle by cycle against the timing formulas.
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input bit loop,
                         input int d, input bit probe_end);
    int          len;
    int          wave_err = 0, mosi_err = 0, rises = 0;
    logic [31:0] r;
    len = 16 * (d + 1);
    load_slave(slv, loop);
    wb_write(AdrData, {24'h0, tx}, 4'h1);
    fork
      begin
        logic prev = 1'b0;
        for (int i = 0; i <= len; i++) begin
          int   h;
          logic es;
          h  = i / (d + 1);
          es = (i < len) ? h[0] : 1'b0;
          if (sclk !== es) wave_err++;
          if (i < len && mosi !== tx[7 - h / 2]) mosi_err++;
          if (!prev && sclk) rises++;
          prev = sclk;
          if (i < len) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        logic [31:0] s1, s2;
        int p;
        wb_read(AdrStatus, s1);
        check("xfer_busy_start", s1, 32'h1);
        p = probe_end ? len - 1 : len - 2;
        repeat (p - 2) @(posedge clk);
        #1;
        wb_read(AdrStatus, s2);
        if (probe_end) check("xfer_status_at_end", s2, 32'h8);
        else check("xfer_status_last", s2, 32'h1);
      end
    join
    check("sclk_wave", 32'(wave_err), 32'd0);
    check("mosi_wave", 32'(mosi_err), 32'd0);
    check("sclk_rises", 32'(rises), 32'd8);
    wb_read(AdrStatus, r);
    check("xfer_done", r, 32'h8);
    wb_read(AdrData, r);
    check("xfer_rx", r, {24'h0, loop ? tx : slv});
    check("slave_got_tx", {24'h0, slave_rx}, {24'h0, tx});
    wb_write(AdrStatus, 32'h8, 4'h1);
    wb_read(AdrStatus, r);
    check("done_w1c", r, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [31:0] r;

    vecs[0]  = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h100};
    vecs[1]  = '{1'b0, AdrStatus, 32'h0,        4'hF, 32'h0};
    vecs[2]  = '{1'b0, AdrData,   32'h0,        4'hF, 32'h0};
    vecs[3]  = '{1'b0, AdrRsvd,   32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, AdrCtrl,   32'h605,      4'hF, 32'h0};
    vecs[5]  = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h605};
    vecs[6]  = '{1'b1, AdrCtrl,   32'h0,        4'h1, 32'h0};
    vecs[7]  = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h600};
    vecs[8]  = '{1'b1, AdrRsvd,   32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, AdrRsvd,   32'h0,        4'hF, 32'h0};
    vecs[10] = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h600};
    vecs[11] = '{1'b1, AdrCtrl,   32'hFFFFF0FF, 4'h2, 32'h0};
    vecs[12] = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h0};
    vecs[13] = '{1'b1, AdrCtrl,   32'h203,      4'h3, 32'h0};
    vecs[14] = '{1'b0, AdrCtrl,   32'h0,        4'hF, 32'h203};
    vecs[15] = '{1'b1, AdrStatus, 32'hF,        4'hF, 32'h0};
    vecs[16] = '{1'b0, AdrStatus, 32'h0,        4'hF, 32'h0};
    vecs[17] = '{1'b1, AdrData,   32'h77,       4'h2, 32'h0};
    vecs[18] = '{1'b0, AdrStatus, 32'h0,        4'hF, 32'h0};

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ext_n", 32'(ext_n), 32'd0);
    check("rst_irq_o", 32'(irq_out), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat_o", rdat, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      end else begin
        wb_read(vecs[i].adr, r);
        check($sformatf("vec%0d_read", i), r, vecs[i].exp);
      end
    end
    check("pin_csn_low", 32'(csn), 32'd0);
    check("pin_ext_n_high", 32'(ext_n), 32'd1);
    check("pin_irq_o_low", 32'(irq_out), 32'd0);

    // Loopback transfer, D=3
    do_xfer(8'hA5, 8'h00, 1'b1, 3, 1'b1);

    // DATA write while busy: ignored, ovr set
    load_slave(8'hC3, 1'b0);
    wb_write(AdrData, 32'h5A, 4'h1);
    wb_write(AdrData, 32'h3C, 4'h1);
    begin
      int polls = 0;
      do begin
        wb_read(AdrStatus, r);
        polls++;
      end while (r[0] && polls < 40);
      check("ovr_status", r, 32'hA);
    end
    check("ovr_slave_got", {24'h0, slave_rx}, 32'h5A);
    wb_read(AdrData, r);
    check("ovr_rx", r, 32'hC3);
    wb_write(AdrStatus, 32'h2, 4'h1);
    wb_read(AdrStatus, r);
    check("ovr_w1c", r, 32'h8);
    wb_write(AdrStatus, 32'h8, 4'h1);

    // Interrupt synchronizer and mask
    irq_in = 1'b1;
    wb_read(AdrStatus, r);
    check("irq_sync_1cyc", r, 32'h0);
    wb_read(AdrStatus, r);
    check("irq_sync_raw", r, 32'h4);
    check("irq_masked", 32'(irq_out), 32'd0);
    wb_write(AdrCtrl, 32'h603, 4'h2);
    check("irq_enabled", 32'(irq_out), 32'd1);
    irq_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("irq_dropped", 32'(irq_out), 32'd0);
    wb_write(AdrCtrl, 32'h203, 4'h2);

    // Randomized transfers against the slave model
    for (int n = 0; n < 6; n++) begin
      int         d;
      logic [7:0] tx, slv;
      bit         lp;
      d   = int'($urandom_range(2, 5));
      tx  = 8'($urandom);
      slv = 8'($urandom);
      lp  = 1'($urandom_range(0, 1));
      wb_write(AdrCtrl, 32'h200 | 32'(d), 4'h3);
      do_xfer(tx, slv, lp, d, 1'(n % 2));
    end

    // Reset mid-transfer at cycle 20 of a D=3 transfer
    wb_write(AdrCtrl, 32'h203, 4'h3);
    load_slave(8'hFF, 1'b0);
    wb_write(AdrData, 32'h96, 4'h1);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_pre_sclk", 32'(sclk), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_csn", 32'(csn), 32'd1);
    check("midrst_ext_n", 32'(ext_n), 32'd0);
    wb_read(AdrStatus, r);
    check("midrst_status", r, 32'h0);
    wb_read(AdrData, r);
    check("midrst_rx", r, 32'h0);
    wb_read(AdrCtrl, r);
    check("midrst_ctrl", r, 32'h100);
    wb_write(AdrCtrl, 32'h203, 4'h3);
    do_xfer(8'h69, 8'h2D, 1'b0, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
